// File: rtl/rx_iq_buffer.sv
// Elastic I/Q sample FIFO between the DDC output and the MCU nibble interface.
// A pop loads one pair into registered outputs, where it stays until the next pop.
module rx_iq_buffer #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic [15:0]   in_I,
   input  logic [15:0]   in_Q,
   input  logic          in_valid,
   input  logic          rd_req,
   input  logic          flags_clr,
   output logic [15:0]   out_I,
   output logic [15:0]   out_Q,
   output logic          out_fresh,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic          underrun
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          do_wr;
   logic          do_pop;
   logic          drop;
   logic          starve;
   logic [AW:0]   level_nxt;

   // A pop frees a slot in the same cycle, so a write into a full buffer is
   // accepted when rd_req is high.
   always_comb begin
      do_pop    = rd_req & ~empty;
      do_wr     = in_valid & (~full | rd_req);
      drop      = in_valid & full & ~rd_req;
      starve    = rd_req & empty;
      level_nxt = level;
      if (do_wr && !do_pop)
         level_nxt = level + ONE_LVL;
      else if (do_pop && !do_wr)
         level_nxt = level - ONE_LVL;
   end

   // Storage is not reset; pointers and level define what is valid.
   always_ff @(posedge clk_in) begin
      if (do_wr && !reset)
         mem[wp] <= {in_Q, in_I};
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         wp        <= '0;
         rp        <= '0;
         level     <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         out_I     <= '0;
         out_Q     <= '0;
         out_fresh <= 1'b0;
         overflow  <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (do_wr)
            wp <= wp + 1'b1;
         // When full, wp == rp: the read sees the old (oldest) entry.
         if (do_pop) begin
            {out_Q, out_I} <= mem[rp];
            rp             <= rp + 1'b1;
         end
         if (rd_req)
            out_fresh <= do_pop;
         level    <= level_nxt;
         empty    <= (level_nxt == '0);
         full     <= (level_nxt == FULL_LVL);
         overflow <= drop   | (overflow & ~flags_clr);
         underrun <= starve | (underrun & ~flags_clr);
      end
   end

endmodule

// File: doc/rx_iq_buffer.md
# rx_iq_buffer

Elastic sample buffer between the DDC decimator output and the STM32 nibble interface. Absorbs bursty decimated I/Q samples and keeps them until the MCU pulls them through an RX IQ transfer (command code 4). Each MCU read pops one I/Q pair, and the pair is held stable on the outputs for the whole 8-nibble serialisation. Overflow and underrun are recorded in sticky status bits that the MCU can inspect.

## Interface
- DEPTH, 16, number of I/Q pair entries; power of two, 4..256
- AW, log2(DEPTH), address width; derived, not overridden
- clk_in  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_I  in  16  signed I sample from the DDC
- in_Q  in  16  signed Q sample from the DDC
- in_valid  in  1  write strobe; one pair per high cycle
- rd_req  in  1  pop request; one pop per high cycle (driven by DATA_SYNC with code 4)
- flags_clr  in  1  clears overflow and underrun
- out_I  out  16  signed I of the last popped pair
- out_Q  out  16  signed Q of the last popped pair
- out_fresh  out  1  1 = last rd_req delivered a new pair; 0 = it repeated the old pair
- level  out  AW+1  entries stored, 0..DEPTH
- empty  out  1  level==0
- full  out  1  level==DEPTH
- overflow  out  1  sticky: a write was dropped
- underrun  out  1  sticky: a read found the buffer empty

## Operation
- Storage: DEPTH x 32-bit circular RAM. Entry = {Q,I}. Write pointer wp and read pointer rp are AW-bit wide and wrap modulo DEPTH. Level is a separate AW+1-bit counter.
- Write, when in_valid and (not full, or rd_req in the same cycle):
  - store at wp
  - wp+1
- Write when full and rd_req low:
  - sample dropped
  - overflow set to 1
  - wp and level unchanged
- Read, when rd_req and not empty:
  - out_I/out_Q are loaded from rp
  - rp+1
  - out_fresh set to 1
- Read when empty:
  - out_I/out_Q keep their values
  - out_fresh set to 0
  - underrun set to 1
  - rp unchanged
  - An in_valid in the same cycle is still written. The new sample is not bypassed to the outputs.
- Level update: +1 on an accepted write with no pop, -1 on a pop with no accepted write, unchanged on both or neither.
- Simultaneous write and pop when full: both happen and level stays DEPTH. Overflow is not set.
- flags_clr clears both sticky flags. If a set event happens in the same cycle, the set wins.
- No arithmetic is applied to samples. Values pass through bit-exact, including -32768.
- reset aborts everything in progress. Stored contents are discarded logically, because pointers and level return to 0. The RAM itself is not cleared.

## Timing
- Reset values:
  - out_I = 0, out_Q = 0, out_fresh = 0
  - level = 0, empty = 1, full = 0
  - overflow = 0, underrun = 0
- All outputs are registered.
- Pop latency: rd_req is sampled at edge N, and out_I/out_Q are valid after edge N. This matches the interface loading I/Q at edge N+1, its first state after sync.
- Outputs are stable between pops, so the interface can serialise across the following 8 cycles.
- Write-to-read latency: a sample written at edge N can be popped by an rd_req sampled at edge N+1 or later.
- level, empty and full reflect the state after each edge, with no lag. Throughput is one write and one pop per cycle.

## Test plan
- Reset, then 3 writes (I,Q) = (1,-1), (2,-2), (3,-3) → level = 3, empty = 0. Three single-cycle rd_req give out = (1,-1), (2,-2), (3,-3) in order, each after its request edge, all with out_fresh = 1. Final level = 0, empty = 1.
- Write 17 pairs with DEPTH = 16 and no reads → full = 1, level = 16, overflow = 1. The 17th pair is lost: 16 pops return pairs 1..16.
- Pop from an empty buffer after out = (7,8) → out stays (7,8), out_fresh = 0, underrun = 1. flags_clr then clears it to 0. A simultaneous underrun and flags_clr leaves underrun = 1.
- When full, in_valid and rd_req in the same cycle → the oldest pair is output, the new pair is stored, level stays 16, overflow stays 0.
- Wrap-around over 40 write/pop cycles with pattern I = n, Q = -n → every pop matches, with no drops and no duplicates. Include I = 0x8000 and Q = 0x7FFF to check bit-exact pass-through.
- Assert reset with level = 5 and a pop in progress → the next cycle shows level = 0, empty = 1, out_I = out_Q = 0, both flags 0. A subsequent write/pop works normally.
